// File: rtl/op_pkg.sv
// ============================================================================
// Module      : op_pkg
// Description : Shared definitions for the operand packer and the two-lane
//               adder pipeline wrapper. It provides the operand width, the lane
//               count, the slot index type and the operand bundle layout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package op_pkg;

  localparam int OP_W  = 10;
  localparam int LANES = 4;

  // Index of the next lane to fill within a group (0..LANES-1)
  typedef logic [1:0] slot_t;

  // Slot holding the final word of a group. That word bypasses storage.
  localparam slot_t LAST_SLOT = 2'd3;

  // One operand bundle, in the order the adder consumes it
  typedef struct packed {
    logic [OP_W-1:0] a0;
    logic [OP_W-1:0] b0;
    logic [OP_W-1:0] a1;
    logic [OP_W-1:0] b1;
  } op_bundle_t;

endpackage : op_pkg

`default_nettype wire

// File: rtl/op_hold_reg.sv
// ============================================================================
// Module      : op_hold_reg
// Description : Output bundle register for the operand packer. It holds one
//               bundle behind a valid/ready handshake and resolves a new load
//               arriving in the same cycle as a delivery. It also counts the
//               delivered bundles.
// Ports       : clk, rst_n        - clock, synchronous active-low reset
//               load              - capture ld_* lanes this cycle
//               ld_a0..ld_b1      - bundle to capture
//               out_ready         - downstream accepts the held bundle
//               out_valid         - a bundle is held
//               a0, b0, a1, b1    - held bundle lanes
//               grp_cnt           - delivered-bundle count, wraps
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module op_hold_reg
  import op_pkg::*;
#(
  parameter int W     = OP_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [W-1:0]     ld_a0,
  input  logic [W-1:0]     ld_b0,
  input  logic [W-1:0]     ld_a1,
  input  logic [W-1:0]     ld_b1,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [W-1:0]     a0,
  output logic [W-1:0]     b0,
  output logic [W-1:0]     a1,
  output logic [W-1:0]     b1,
  output logic [CNT_W-1:0] grp_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [W-1:0]     a0_q, a0_d, b0_q, b0_d, a1_q, a1_d, b1_q, b1_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             deliver;

  always_comb begin
    a0_d    = a0_q;
    b0_d    = b0_q;
    a1_d    = a1_q;
    b1_d    = b1_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    deliver = valid_q && out_ready;

    // A load takes priority. If it coincides with a delivery, the register
    // refills and valid stays high. Data is left in place on a bare delivery.
    if (load) begin
      a0_d    = ld_a0;
      b0_d    = ld_b0;
      a1_d    = ld_a1;
      b1_d    = ld_b1;
      valid_d = 1'b1;
    end else if (deliver) begin
      valid_d = 1'b0;
    end

    if (deliver) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a0_q    <= '0;
      b0_q    <= '0;
      a1_q    <= '0;
      b1_q    <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a0_q    <= a0_d;
      b0_q    <= b0_d;
      a1_q    <= a1_d;
      b1_q    <= b1_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign a0        = a0_q;
  assign b0        = b0_q;
  assign a1        = a1_q;
  assign b1        = b1_q;
  assign grp_cnt   = cnt_q;

endmodule : op_hold_reg

`default_nettype wire

// File: rtl/operand_packer.sv
// ============================================================================
// Module      : operand_packer
// Description : Serial-to-parallel front end for the two-lane adder. It
//               gathers four accepted operand words into one bundle
//               (a0, b0, a1, b1) and presents the bundle through a registered
//               valid/ready output.
// Ports       : clk, rst_n        - clock, synchronous active-low reset
//               flush             - discard the partially collected group
//               in_data/in_valid/in_ready      - serial word stream
//               a0, b0, a1, b1, out_valid/out_ready - bundle stream
//               grp_cnt           - delivered-bundle count, wraps
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_packer
  import op_pkg::*;
#(
  parameter int W     = OP_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     a0,
  output logic [W-1:0]     b0,
  output logic [W-1:0]     a1,
  output logic [W-1:0]     b1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] grp_cnt
);

  slot_t        slot_q, slot_d;
  logic [W-1:0] col0_q, col0_d, col1_q, col1_d, col2_q, col2_d;
  logic         accept;
  logic         load;

  // Only the closing word of a group needs room in the output register, so
  // only slot 3 can stall, and only while an undelivered bundle is held.
  assign in_ready = !flush && ((slot_q != LAST_SLOT) || !out_valid || out_ready);

  always_comb begin
    slot_d = slot_q;
    col0_d = col0_q;
    col1_d = col1_q;
    col2_d = col2_q;
    accept = in_valid && in_ready;
    load   = accept && (slot_q == LAST_SLOT);

    if (flush) begin
      slot_d = '0;
      col0_d = '0;
      col1_d = '0;
      col2_d = '0;
    end else if (accept) begin
      case (slot_q)
        2'd0:    col0_d = in_data;
        2'd1:    col1_d = in_data;
        2'd2:    col2_d = in_data;
        default: ;  // the last word feeds the output register directly
      endcase
      slot_d = (slot_q == LAST_SLOT) ? slot_t'(0) : slot_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q <= '0;
      col0_q <= '0;
      col1_q <= '0;
      col2_q <= '0;
    end else begin
      slot_q <= slot_d;
      col0_q <= col0_d;
      col1_q <= col1_d;
      col2_q <= col2_d;
    end
  end

  op_hold_reg #(
    .W     (W),
    .CNT_W (CNT_W)
  ) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .ld_a0     (col0_q),
    .ld_b0     (col1_q),
    .ld_a1     (col2_q),
    .ld_b1     (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .a0        (a0),
    .b0        (b0),
    .a1        (a1),
    .b1        (b1),
    .grp_cnt   (grp_cnt)
  );

endmodule : operand_packer

`default_nettype wire

// File: tb/tb_operand_packer.sv
// ============================================================================
// Module      : tb_operand_packer
// Description : Self-checking bench for operand_packer. A queue-based model
//               of the packer is compared against the DUT on every cycle.
//               Directed scenarios pin both the model and the DUT with
//               hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_packer;

  localparam int W     = 10;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic [W-1:0]     in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     a0, b0, a1, b1;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] grp_cnt;

  always #5 clk = ~clk;

  operand_packer #(.W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a0        (a0),
    .b0        (b0),
    .a1        (a1),
    .b1        (b1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grp_cnt   (grp_cnt)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input int unsigned got, input int unsigned exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Pending words sit in a queue. A full group of four becomes the held
  // bundle. The counter counts handshakes.
  int unsigned      m_col[$];
  int unsigned      m_lane[4];
  bit               m_valid = 1'b0;
  logic [CNT_W-1:0] m_cnt = '0;

  function automatic bit m_ready();
    return !flush && (m_col.size() < 3 || !m_valid || out_ready);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_col.delete();
      m_lane  = '{default: 0};
      m_valid = 1'b0;
      m_cnt   = '0;
    end else begin
      bit dlv, acc, ld;
      dlv = m_valid && out_ready;
      acc = in_valid && m_ready();
      ld  = 1'b0;
      if (flush) begin
        m_col.delete();
      end else if (acc) begin
        m_col.push_back(int'(in_data));
        if (m_col.size() == 4) begin
          for (int i = 0; i < 4; i++) m_lane[i] = m_col[i];
          m_col.delete();
          ld = 1'b1;
        end
      end
      if (ld) m_valid = 1'b1;
      else if (dlv) m_valid = 1'b0;
      if (dlv) m_cnt = m_cnt + 1'b1;
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_in_ready", 32'(in_ready), 32'(m_ready()));
      chk("cyc_out_valid", 32'(out_valid), 32'(m_valid));
      chk("cyc_grp_cnt", 32'(grp_cnt), 32'(m_cnt));
      chk("cyc_a0", 32'(a0), m_lane[0]);
      chk("cyc_b0", 32'(b0), m_lane[1]);
      chk("cyc_a1", 32'(a1), m_lane[2]);
      chk("cyc_b1", 32'(b1), m_lane[3]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int unsigned v);
    in_valid = 1'b1;
    in_data  = W'(v);
    step();
  endtask

  task automatic chk_lanes(input string nm, input int unsigned e0, input int unsigned e1,
                           input int unsigned e2, input int unsigned e3);
    chk({nm, "_a0"}, 32'(a0), e0);
    chk({nm, "_b0"}, 32'(b0), e1);
    chk({nm, "_a1"}, 32'(a1), e2);
    chk({nm, "_b1"}, 32'(b1), e3);
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 1);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_grp_cnt", 32'(grp_cnt), 0);
    chk_lanes("rst", 0, 0, 0, 0);

    // Single group
    out_ready = 1'b1;
    for (int v = 1; v <= 4; v++) feed(v);
    chk("single_valid", 32'(out_valid), 1);
    chk_lanes("single", 1, 2, 3, 4);
    chk("model_a0", m_lane[0], 1);
    chk("model_b1", m_lane[3], 4);
    in_valid = 1'b0;
    step();
    chk("single_valid_drop", 32'(out_valid), 0);
    chk("single_grp_cnt", 32'(grp_cnt), 1);
    chk("model_cnt", 32'(m_cnt), 1);

    // Back-pressure
    out_ready = 1'b0;
    for (int v = 10; v <= 16; v++) feed(v);
    chk("bp_valid", 32'(out_valid), 1);
    chk_lanes("bp_hold", 10, 11, 12, 13);
    in_valid = 1'b1;
    in_data  = W'(17);
    #1;
    chk("bp_stall", 32'(in_ready), 0);
    step();
    chk_lanes("bp_hold2", 10, 11, 12, 13);
    out_ready = 1'b1;
    step();
    chk("bp_swap_valid", 32'(out_valid), 1);
    chk_lanes("bp_swap", 14, 15, 16, 17);
    chk("bp_grp_cnt", 32'(grp_cnt), 2);
    in_valid = 1'b0;
    step();
    chk("bp_drain_valid", 32'(out_valid), 0);
    chk("bp_drain_cnt", 32'(grp_cnt), 3);

    // Flush
    feed(32'h3FF);
    feed(32'h001);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = W'(32'h155);
    #1;
    chk("flush_in_ready", 32'(in_ready), 0);
    step();
    flush = 1'b0;
    for (int v = 5; v <= 8; v++) feed(v);
    chk("flush_valid", 32'(out_valid), 1);
    chk_lanes("flush", 5, 6, 7, 8);
    in_valid = 1'b0;
    step();

    // Counter wrap
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 255 * 4; i++) feed($urandom);
    in_valid = 1'b0;
    step();
    step();
    chk("wrap_255", 32'(grp_cnt), 255);
    for (int i = 0; i < 4; i++) feed($urandom);
    in_valid = 1'b0;
    step();
    step();
    chk("wrap_0", 32'(grp_cnt), 0);

    // Reset mid-operation
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) feed($urandom_range(1, 1023));
    chk("midrst_pre_valid", 32'(out_valid), 1);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_cnt", 32'(grp_cnt), 0);
    chk_lanes("midrst", 0, 0, 0, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) feed(7);
    chk("midrst_after_valid", 32'(out_valid), 1);
    chk_lanes("midrst_after", 7, 7, 7, 7);
    in_valid = 1'b0;
    step();

    // Randomized traffic with varying back-pressure
    for (int seg = 0; seg < 6; seg++) begin
      int unsigned rdy_pct;
      rdy_pct = (seg % 3 == 0) ? 20 : ((seg % 3 == 1) ? 60 : 95);
      for (int c = 0; c < 500; c++) begin
        rst_n     = ($urandom_range(0, 299) != 0);
        flush     = ($urandom_range(0, 24) == 0);
        in_valid  = ($urandom_range(0, 3) != 0);
        in_data   = W'($urandom);
        out_ready = ($urandom_range(0, 99) < rdy_pct);
        step();
      end
    end
    rst_n    = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    step();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_operand_packer

`default_nettype wire
